velocity_ramp_scheduler: RTL

VELOCITY_RAMP_SCHEDULER -- requirements
Module: velocity_ramp_scheduler

---
 rtl/velocity_ramp_scheduler_pkg.sv | 18 +
 rtl/velocity_slew_step.sv | 30 +++
 rtl/velocity_ramp_scheduler.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/velocity_ramp_scheduler_pkg.sv
// Shared types and default sizing for the velocity ramp scheduler.
// Q(N_WIDTH-Q_WIDTH).Q_WIDTH signed velocity words; one ramp tick every TICK_DIV clocks.
package velocity_ramp_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    HOLD = 2'd2,
    STOP = 2'd3
  } rampState_t;

  localparam int DEFAULT_N_WIDTH       = 17;
  localparam int DEFAULT_Q_WIDTH       = 8;
  localparam int DEFAULT_TICK_DIV      = 50000;
  localparam int DEFAULT_STEP          = 64;
  localparam int DEFAULT_TIMEOUT_TICKS = 500;

endpackage

// File: rtl/velocity_slew_step.sv
// One axis of the slew limiter: moves current toward goal by at most step, purely combinational.
// The difference is formed one bit wider so any pair of N_WIDTH operands is handled without overflow.
module velocity_slew_step
  import velocity_ramp_scheduler_pkg::*;
#(
  parameter int N_WIDTH = DEFAULT_N_WIDTH
) (
  input  logic signed [N_WIDTH-1:0] current,
  input  logic signed [N_WIDTH-1:0] goal,
  input  logic signed [N_WIDTH-1:0] step,
  output logic signed [N_WIDTH-1:0] nextVal
);

  logic signed [N_WIDTH:0] diff;
  logic signed [N_WIDTH:0] absDiff;

  always_comb begin
    diff    = {goal[N_WIDTH-1], goal} - {current[N_WIDTH-1], current};
    absDiff = diff[N_WIDTH] ? -diff : diff;
    // A full step only happens when the goal lies beyond it, so current +/- step cannot wrap.
    if (absDiff <= {step[N_WIDTH-1], step}) begin
      nextVal = goal;
    end else if (diff[N_WIDTH]) begin
      nextVal = current - step;
    end else begin
      nextVal = current + step;
    end
  end

endmodule

// File: rtl/velocity_ramp_scheduler.sv
// Slew-limited velocity target scheduler with stop priority; targets move at most STEP per tick.
// Optional HOLD watchdog enabled by defining VELOCITY_RAMP_WATCHDOG_EN.
module velocity_ramp_scheduler
  import velocity_ramp_scheduler_pkg::*;
#(
  parameter int N_WIDTH       = DEFAULT_N_WIDTH,
  parameter int Q_WIDTH       = DEFAULT_Q_WIDTH,
  parameter int TICK_DIV      = DEFAULT_TICK_DIV,
  parameter int STEP          = DEFAULT_STEP,
  parameter int TIMEOUT_TICKS = DEFAULT_TIMEOUT_TICKS
) (
  input  logic                      VELOCITY_RAMP_SCHEDULER_CLOCK_50,
  input  logic                      VELOCITY_RAMP_SCHEDULER_RESET_InLow,
  input  logic signed [N_WIDTH-1:0] VELOCITY_RAMP_SCHEDULER_CMDVX_InBus,
  input  logic signed [N_WIDTH-1:0] VELOCITY_RAMP_SCHEDULER_CMDVY_InBus,
  input  logic signed [N_WIDTH-1:0] VELOCITY_RAMP_SCHEDULER_CMDWZ_InBus,
  input  logic                      VELOCITY_RAMP_SCHEDULER_CMDVALID_In,
  output logic                      VELOCITY_RAMP_SCHEDULER_CMDREADY_Out,
  input  logic                      VELOCITY_RAMP_SCHEDULER_STOP_In,
  output logic signed [N_WIDTH-1:0] VELOCITY_RAMP_SCHEDULER_TARGETVX_OutBus,
  output logic signed [N_WIDTH-1:0] VELOCITY_RAMP_SCHEDULER_TARGETVY_OutBus,
  output logic signed [N_WIDTH-1:0] VELOCITY_RAMP_SCHEDULER_TARGETWZ_OutBus,
  output logic                      VELOCITY_RAMP_SCHEDULER_BUSY_Out,
  output logic                      VELOCITY_RAMP_SCHEDULER_TIMEOUT_Out
);

  localparam int PRE_W = $clog2(TICK_DIV + 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic signed [N_WIDTH-1:0] STEP_Q = N_WIDTH'(STEP);

  if (Q_WIDTH >= N_WIDTH || STEP < 1 || TICK_DIV < 1 || TIMEOUT_TICKS < 1) begin : gBadParams
    $error("velocity_ramp_scheduler: inconsistent parameters");
  end

  wire clk  = VELOCITY_RAMP_SCHEDULER_CLOCK_50;
  wire rstN = VELOCITY_RAMP_SCHEDULER_RESET_InLow;
  wire stop = VELOCITY_RAMP_SCHEDULER_STOP_In;
  wire cmdValid = VELOCITY_RAMP_SCHEDULER_CMDVALID_In;

  rampState_t state, stateNext;
  logic [PRE_W-1:0] prescaler;
  logic tick, cmdReady, busy, loadGoals, zeroGoals, atGoal, targetsZero, updateTargets;
  logic signed [N_WIDTH-1:0] goalVx, goalVy, goalWz;
  logic signed [N_WIDTH-1:0] targetVx, targetVy, targetWz;
  logic signed [N_WIDTH-1:0] nextVx, nextVy, nextWz;

  assign tick = (prescaler == PRE_LAST);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) prescaler <= '0;
    else       prescaler <= tick ? '0 : prescaler + 1'b1;
  end

  velocity_slew_step #(.N_WIDTH(N_WIDTH)) slewVx (.current(targetVx), .goal(goalVx), .step(STEP_Q), .nextVal(nextVx));
  velocity_slew_step #(.N_WIDTH(N_WIDTH)) slewVy (.current(targetVy), .goal(goalVy), .step(STEP_Q), .nextVal(nextVy));
  velocity_slew_step #(.N_WIDTH(N_WIDTH)) slewWz (.current(targetWz), .goal(goalWz), .step(STEP_Q), .nextVal(nextWz));

  // Judged on the post-update values so arrival is recognised on the tick that lands it.
  assign atGoal        = (nextVx == goalVx) && (nextVy == goalVy) && (nextWz == goalWz);
  assign targetsZero   = (targetVx == '0) && (targetVy == '0) && (targetWz == '0);
  assign updateTargets = tick && (state == RAMP || state == STOP);

`ifdef VELOCITY_RAMP_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_TICKS + 1);
  logic [WD_W-1:0] wdCnt;
  logic timeoutFlag, wdHit, wdTrip, wdBump;
  assign wdHit = tick && (wdCnt == WD_W'(TIMEOUT_TICKS - 1));
`endif

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    cmdReady  = 1'b0;
    busy      = 1'b0;
    loadGoals = 1'b0;
    zeroGoals = 1'b0;
`ifdef VELOCITY_RAMP_WATCHDOG_EN
    wdTrip = 1'b0;
    wdBump = 1'b0;
`endif
    case (state)
      IDLE: begin
        cmdReady = 1'b1;
        if (cmdValid) begin
          stateNext = RAMP;
          loadGoals = 1'b1;
        end
      end
      RAMP: begin
        busy = 1'b1;
        if (tick && atGoal) stateNext = HOLD;
      end
      HOLD: begin
        cmdReady = 1'b1;
        if (cmdValid) begin
          stateNext = RAMP;
          loadGoals = 1'b1;
        end else if (targetsZero) begin
          stateNext = IDLE;
        end
`ifdef VELOCITY_RAMP_WATCHDOG_EN
        else if (wdHit) begin
          stateNext = RAMP;
          zeroGoals = 1'b1;
          wdTrip    = 1'b1;
        end else if (tick) begin
          wdBump = 1'b1;
        end
`endif
      end
      STOP: begin
        busy = 1'b1;
        if (tick && atGoal && !stop) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
    // Stop overrides everything, including a command handshake in the same cycle.
    if (stop) begin
      stateNext = STOP;
      loadGoals = 1'b0;
      zeroGoals = 1'b1;
`ifdef VELOCITY_RAMP_WATCHDOG_EN
      wdTrip = 1'b0;
      wdBump = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      goalVx <= '0; goalVy <= '0; goalWz <= '0;
      targetVx <= '0; targetVy <= '0; targetWz <= '0;
    end else begin
      if (zeroGoals) begin
        goalVx <= '0; goalVy <= '0; goalWz <= '0;
      end else if (loadGoals) begin
        goalVx <= VELOCITY_RAMP_SCHEDULER_CMDVX_InBus;
        goalVy <= VELOCITY_RAMP_SCHEDULER_CMDVY_InBus;
        goalWz <= VELOCITY_RAMP_SCHEDULER_CMDWZ_InBus;
      end
      if (updateTargets) begin
        targetVx <= nextVx; targetVy <= nextVy; targetWz <= nextWz;
      end
    end
  end

`ifdef VELOCITY_RAMP_WATCHDOG_EN
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wdCnt       <= '0;
      timeoutFlag <= 1'b0;
    end else if (loadGoals) begin
      wdCnt       <= '0;
      timeoutFlag <= 1'b0;
    end else if (wdTrip) begin
      wdCnt       <= '0;
      timeoutFlag <= 1'b1;
    end else if (wdBump) begin
      wdCnt <= wdCnt + 1'b1;
    end
  end
  assign VELOCITY_RAMP_SCHEDULER_TIMEOUT_Out = timeoutFlag;
`else
  assign VELOCITY_RAMP_SCHEDULER_TIMEOUT_Out = 1'b0;
`endif

  assign VELOCITY_RAMP_SCHEDULER_CMDREADY_Out    = cmdReady;
  assign VELOCITY_RAMP_SCHEDULER_BUSY_Out        = busy;
  assign VELOCITY_RAMP_SCHEDULER_TARGETVX_OutBus = targetVx;
  assign VELOCITY_RAMP_SCHEDULER_TARGETVY_OutBus = targetVy;
  assign VELOCITY_RAMP_SCHEDULER_TARGETWZ_OutBus = targetWz;

endmodule
